// File: rtl/microondas_pkg.sv
// Shared constants and types for the microwave keypad encoder path.
package microondas_pkg;

    localparam int NUM_KEYS   = 10;
    localparam int MAX_DIGITS = 4;
    localparam int BCD_W      = 4;

    // Digit positions inside time_bcd: {d3,d2,d1,d0} = mm:ss
    localparam int D0_IDX = 0;  // seconds units
    localparam int D1_IDX = 1;  // seconds tens
    localparam int D2_IDX = 2;  // minutes units
    localparam int D3_IDX = 3;  // minutes tens

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_CAPTURE      = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } entry_state_e;

endpackage : microondas_pkg

// File: rtl/onehot_to_bcd.sv
// Combinational encoder: index of the single set bit, plus a flag that is
// high only when exactly one bit is set. Shared with the function-key path.
module onehot_to_bcd
    import microondas_pkg::*;
#(
    parameter int N = NUM_KEYS
) (
    input  logic [N-1:0]     onehot_i,
    output logic [BCD_W-1:0] index_o,
    output logic             valid_o
);

    localparam int CNT_W = $clog2(N + 1);

    logic [CNT_W-1:0] ones_s;
    logic [BCD_W-1:0] index_s;

    // Count set bits and remember the position of the highest one seen.
    always_comb begin
        ones_s  = {CNT_W{1'b0}};
        index_s = {BCD_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (onehot_i[i]) begin
                ones_s  = ones_s + {{(CNT_W-1){1'b0}}, 1'b1};
                index_s = i[BCD_W-1:0];
            end else begin
                ones_s  = ones_s;
            end
        end
    end

    assign index_o = index_s;
    assign valid_o = (ones_s == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule : onehot_to_bcd

// File: rtl/keypad_digit_entry.sv
// Numeric keypad digit entry: captures one digit per debounced press and
// shifts it into a 4-digit mm:ss BCD buffer that the cook timer loads.
module keypad_digit_entry
    import microondas_pkg::*;
#(
    parameter int NUM_KEYS_P   = NUM_KEYS,
    parameter int MAX_DIGITS_P = MAX_DIGITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_KEYS_P-1:0]         keys,
    input  logic                          key_stable,
    input  logic                          cancel,
    input  logic                          load_ack,
    output logic [BCD_W-1:0]              bcd_digit,
    output logic                          digit_valid,
    output logic                          key_error,
    output logic [BCD_W*MAX_DIGITS_P-1:0] time_bcd,
    output logic [2:0]                    digit_count,
    output logic                          full
);

    localparam int TW = BCD_W * MAX_DIGITS_P;

    entry_state_e            state_q, state_d;
    logic [NUM_KEYS_P-1:0]   key_reg_q, key_reg_d;
    logic [BCD_W-1:0]        bcd_digit_q, bcd_digit_d;
    logic                    digit_valid_q, digit_valid_d;
    logic                    key_error_q, key_error_d;
    logic [TW-1:0]           time_bcd_q, time_bcd_d;
    logic [2:0]              digit_count_q, digit_count_d;

    logic [BCD_W-1:0]        enc_index_s;
    logic                    enc_valid_s;
    logic                    full_s;
    logic                    clear_s;

    onehot_to_bcd #(.N(NUM_KEYS_P)) u_enc (
        .onehot_i (key_reg_q),
        .index_o  (enc_index_s),
        .valid_o  (enc_valid_s)
    );

    assign full_s  = (digit_count_q == 3'(MAX_DIGITS_P));
    assign clear_s = cancel | load_ack;

    // Next-state, capture evaluation and buffer update; a clear beats a capture.
    always_comb begin
        state_d       = state_q;
        key_reg_d     = key_reg_q;
        bcd_digit_d   = bcd_digit_q;
        digit_valid_d = 1'b0;
        key_error_d   = 1'b0;
        time_bcd_d    = time_bcd_q;
        digit_count_d = digit_count_q;

        case (state_q)
            ST_IDLE: begin
                if (key_stable) begin
                    key_reg_d = keys;
                    state_d   = ST_CAPTURE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_WAIT_RELEASE;
                if (clear_s) begin
                    digit_valid_d = 1'b0;
                end else if (enc_valid_s && !full_s) begin
                    bcd_digit_d   = enc_index_s;
                    digit_valid_d = 1'b1;
                    time_bcd_d    = {time_bcd_q[TW-BCD_W-1:0], enc_index_s};
                    digit_count_d = digit_count_q + 3'd1;
                end else begin
                    key_error_d   = 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (key_stable) begin
                    state_d = ST_WAIT_RELEASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear_s) begin
            time_bcd_d    = {TW{1'b0}};
            digit_count_d = 3'd0;
        end else begin
            digit_count_d = digit_count_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            key_reg_q     <= {NUM_KEYS_P{1'b0}};
            bcd_digit_q   <= {BCD_W{1'b0}};
            digit_valid_q <= 1'b0;
            key_error_q   <= 1'b0;
            time_bcd_q    <= {TW{1'b0}};
            digit_count_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            key_reg_q     <= key_reg_d;
            bcd_digit_q   <= bcd_digit_d;
            digit_valid_q <= digit_valid_d;
            key_error_q   <= key_error_d;
            time_bcd_q    <= time_bcd_d;
            digit_count_q <= digit_count_d;
        end
    end

    assign bcd_digit   = bcd_digit_q;
    assign digit_valid = digit_valid_q;
    assign key_error   = key_error_q;
    assign time_bcd    = time_bcd_q;
    assign digit_count = digit_count_q;
    assign full        = full_s;

endmodule : keypad_digit_entry
